// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg
//   Shared constants for the 3-digit 7-segment scan path:
//   - NDIG        : number of multiplexed digits
//   - AN_OFF      : all anodes off (active-low)
//   - SEG_BLANK   : all segments off (active-low)
//   - ST_BLANK / ST_SHOW : per-slot phase encoding
//   - HEX_GLYPH   : active-low {g,f,e,d,c,b,a} glyphs for 0..F
//   - hex_glyph() : table lookup helper
package seg_scan_ctrl_pkg;

    localparam int NDIG = 3;

    localparam logic [2:0] AN_OFF    = 3'b111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] val);
        return HEX_GLYPH[val];
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if
//   Bundle between the core-side digit sources and the scan controller.
//   There is no handshake on this bus: digit values, enables and blink
//   requests are level signals sampled every clock; outputs are registered
//   levels (frame_tick is a single-cycle pulse).
//   Signals:
//     d0, d1, d2   : hex nibble per digit (core -> controller)
//     en, blink    : per-digit enable / blink request (core -> controller)
//     seg, an      : active-low segment and anode pins (controller -> board)
//     frame_tick   : pulse on the first cycle of each new frame
//     blink_phase  : 1 = blinking digits currently dark
//     state_dbg    : current slot phase (ST_BLANK / ST_SHOW)
//   Modports: master = digit source side, slave = scan controller.
interface seg_scan_ctrl_if;

    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [2:0] en;
    logic [2:0] blink;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_tick;
    logic       blink_phase;
    logic       state_dbg;

    modport master (
        output d0, d1, d2, en, blink,
        input  seg, an, frame_tick, blink_phase, state_dbg
    );

    modport slave (
        input  d0, d1, d2, en, blink,
        output seg, an, frame_tick, blink_phase, state_dbg
    );

endinterface

// File: rtl/seg_hex_decode.sv
// seg_hex_decode
//   Combinational hex nibble to active-low 7-segment glyph ({g,f,e,d,c,b,a}).
//   Ports:
//     val : 4-bit hex value
//     seg : 7-bit active-low segment pattern
module seg_hex_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    assign seg = hex_glyph(val);

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Round-robin time-multiplexer for a 3-digit common-anode 7-segment display.
//   Each digit owns DIV clock cycles; the first BLANK cycles of a slot keep
//   every anode off to suppress ghosting. The digit value is latched once per
//   slot at the start of its SHOW phase. Per-digit enable and blink are applied
//   every cycle. Blink phase toggles every 2^BLINK_LOG frames.
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous active-high reset
//     bus : seg_scan_ctrl_if.slave (digit inputs, seg/an pins, status)
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIV       = 50000,
    parameter int BLANK     = 500,
    parameter int BLINK_LOG = 6
) (
    input  logic             clk,
    input  logic             rst,
    seg_scan_ctrl_if.slave   bus
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2 || BLANK < 0 || BLANK >= DIV || BLINK_LOG < 1) begin : g_param_check
        $fatal(1, "seg_scan_ctrl: illegal parameters (need DIV>=2, 0<=BLANK<DIV, BLINK_LOG>=1)");
    end

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [BLINK_LOG-1:0] frame_cnt_q, frame_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [3:0]           val_q, val_d;
    logic [0:0]           state_q, state_d;
    logic [2:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;

    logic                 cnt_wrap;
    logic                 frame_end;
    logic [3:0]           digit_sel;
    logic                 lit;
    logic [6:0]           glyph;

    // Decode the post-edge latched value so seg lines up with an.
    seg_hex_decode u_dec (
        .val (val_d),
        .seg (glyph)
    );

    always_comb begin
        cnt_wrap      = (int'(cnt_q) == DIV - 1);
        frame_end     = cnt_wrap && (idx_q == 2'(NDIG - 1));
        cnt_d         = cnt_wrap ? '0 : cnt_q + 1'b1;

        idx_d         = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == 2'(NDIG - 1)) ? 2'd0 : idx_q + 2'd1;
        end

        frame_tick_d  = frame_end;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_end) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            if (frame_cnt_d == '0) begin
                blink_phase_d = ~blink_phase_q;
            end
        end

        state_d = (int'(cnt_d) >= BLANK) ? ST_SHOW : ST_BLANK;

        case (idx_d)
            2'd0:    digit_sel = bus.d0;
            2'd1:    digit_sel = bus.d1;
            default: digit_sel = bus.d2;
        endcase

        // Capture once per slot, on the edge entering SHOW (cnt becomes BLANK).
        val_d = (int'(cnt_d) == BLANK) ? digit_sel : val_q;

        // Everything below uses post-edge values: zero-cycle phase latency.
        lit   = (state_d == ST_SHOW) && bus.en[idx_d] &&
                !(bus.blink[idx_d] && blink_phase_d);
        an_d  = lit ? ~(3'b001 << idx_d) : AN_OFF;
        seg_d = lit ? glyph : SEG_BLANK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            frame_tick_q  <= 1'b0;
            val_q         <= 4'd0;
            state_q       <= ST_BLANK;
            an_q          <= AN_OFF;
            seg_q         <= SEG_BLANK;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            frame_tick_q  <= frame_tick_d;
            val_q         <= val_d;
            state_q       <= state_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.an          = an_q;
    assign bus.frame_tick  = frame_tick_q;
    assign bus.blink_phase = blink_phase_q;
    assign bus.state_dbg   = state_q[0];

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
//   Bench for seg_scan_ctrl. Two instances run side by side:
//     dut_a : DIV=8, BLANK=2, BLINK_LOG=1
//     dut_b : DIV=4, BLANK=0, BLINK_LOG=1 (no blanking)
//   The reference model counts clock edges since reset release and derives
//   slot, digit, frame and blink phase from that count with plain arithmetic.
module tb_seg_scan_ctrl;

  localparam int DIV_A = 8;
  localparam int BLANK_A = 2;
  localparam int DIV_B = 4;
  localparam int BLANK_B = 0;
  localparam int BL_LOG = 1;

  localparam logic [6:0] GLYPH_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_ctrl_if bus_a ();
  seg_scan_ctrl_if bus_b ();

  assign bus_b.d0    = bus_a.d0;
  assign bus_b.d1    = bus_a.d1;
  assign bus_b.d2    = bus_a.d2;
  assign bus_b.en    = bus_a.en;
  assign bus_b.blink = bus_a.blink;

  seg_scan_ctrl #(.DIV(DIV_A), .BLANK(BLANK_A), .BLINK_LOG(BL_LOG)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  seg_scan_ctrl #(.DIV(DIV_B), .BLANK(BLANK_B), .BLINK_LOG(BL_LOG)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // ---------------- scoreboard ----------------
  // Packed observation: {frame_tick, blink_phase, state, an[2:0], seg[6:0]}
  logic [12:0] exp_a_q[$];
  logic [12:0] exp_b_q[$];
  logic [12:0] obs_a, obs_b, exp_a, exp_b;
  int n_a, n_b;
  logic [3:0] val_a, val_b;
  int n_checks = 0;
  int n_pass = 0;

  function automatic logic [3:0] digit_of(input int idx);
    case (idx)
      0: return bus_a.d0;
      1: return bus_a.d1;
      default: return bus_a.d2;
    endcase
  endfunction

  function automatic logic [12:0] model_out(input int n, input int div, input int blank,
                                            input int bl, input logic [2:0] en_v,
                                            input logic [2:0] blink_v, input logic [3:0] val);
    int cnt, idx, frame;
    logic phase, show, lit, ft;
    logic [2:0] an_v;
    logic [6:0] seg_v;
    cnt   = n % div;
    idx   = (n / div) % 3;
    frame = n / (3 * div);
    phase = ((frame / (1 << bl)) % 2) == 1;
    show  = cnt >= blank;
    ft    = (n % (3 * div)) == 0;
    lit   = show && en_v[idx] && !(blink_v[idx] && phase);
    an_v  = lit ? (3'b111 ^ (3'b001 << idx)) : 3'b111;
    seg_v = lit ? GLYPH_REF[val] : 7'h7F;
    return {ft, phase, show, an_v, seg_v};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_a = 0;
      n_b = 0;
      val_a = 4'd0;
      val_b = 4'd0;
      exp_a_q.delete();
      exp_b_q.delete();
    end else begin
      n_a++;
      n_b++;
      if (n_a % DIV_A == BLANK_A) val_a = digit_of((n_a / DIV_A) % 3);
      if (n_b % DIV_B == BLANK_B) val_b = digit_of((n_b / DIV_B) % 3);
      exp_a_q.push_back(model_out(n_a, DIV_A, BLANK_A, BL_LOG, bus_a.en, bus_a.blink, val_a));
      exp_b_q.push_back(model_out(n_b, DIV_B, BLANK_B, BL_LOG, bus_a.en, bus_a.blink, val_b));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    obs_a = {bus_a.frame_tick, bus_a.blink_phase, bus_a.state_dbg, bus_a.an, bus_a.seg};
    obs_b = {bus_b.frame_tick, bus_b.blink_phase, bus_b.state_dbg, bus_b.an, bus_b.seg};
    if (exp_a_q.size() > 0) exp_a = exp_a_q.pop_front(); else exp_a = 'x;
    if (exp_b_q.size() > 0) exp_b = exp_b_q.pop_front(); else exp_b = 'x;
  endtask

  task automatic set_inputs(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2,
                            input logic [2:0] en_v, input logic [2:0] blink_v);
    bus_a.d0 = v0;
    bus_a.d1 = v1;
    bus_a.d2 = v2;
    bus_a.en = en_v;
    bus_a.blink = blink_v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_inputs(4'd1, 4'd2, 4'd3, 3'b111, 3'b000);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus_a.an !== 3'b111) $display("FAIL reset_an_a got=%b exp=111", bus_a.an); else n_pass++;
    n_checks++;
    if (bus_a.seg !== 7'h7F) $display("FAIL reset_seg_a got=%h exp=7f", bus_a.seg); else n_pass++;
    n_checks++;
    if (bus_a.frame_tick !== 1'b0) $display("FAIL reset_tick_a got=%b exp=0", bus_a.frame_tick); else n_pass++;
    n_checks++;
    if (bus_a.blink_phase !== 1'b0) $display("FAIL reset_phase_a got=%b exp=0", bus_a.blink_phase); else n_pass++;
    n_checks++;
    if (bus_b.an !== 3'b111) $display("FAIL reset_an_b got=%b exp=111", bus_b.an); else n_pass++;
    n_checks++;
    if (bus_b.seg !== 7'h7F) $display("FAIL reset_seg_b got=%h exp=7f", bus_b.seg); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int ticks = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (obs_a[12] === 1'b1) ticks++;
      n_checks++;
      if (obs_a !== exp_a) $display("FAIL basic n=%0d got=%h exp=%h", n_a, obs_a, exp_a); else n_pass++;
    end
    n_checks++;
    if (ticks !== 2) $display("FAIL basic_tick_count got=%0d exp=2", ticks); else n_pass++;
  endtask

  task automatic test_data_change();
    int seen = 0;
    for (int i = 0; i < 48 && (n_a % 24) != 12; i++) begin
      step();
      n_checks++;
      if (obs_a !== exp_a) $display("FAIL data_sync n=%0d got=%h exp=%h", n_a, obs_a, exp_a); else n_pass++;
    end
    n_checks++;
    if ((n_a % 24) != 12) $display("FAIL data_reach got=%0d exp=12", n_a % 24); else n_pass++;
    bus_a.d1 = 4'hF;
    for (int i = 0; i < 30; i++) begin
      step();
      n_checks++;
      if (obs_a !== exp_a) $display("FAIL data_change n=%0d got=%h exp=%h", n_a, obs_a, exp_a); else n_pass++;
      if (i < 3) begin
        n_checks++;
        if (obs_a[6:0] !== 7'h24) $display("FAIL data_hold got=%h exp=24", obs_a[6:0]); else n_pass++;
      end
      if (i >= 22 && (n_a % 24) >= 10 && (n_a % 24) <= 15) begin
        seen++;
        n_checks++;
        if (obs_a[6:0] !== 7'h0E) $display("FAIL data_new got=%h exp=0e", obs_a[6:0]); else n_pass++;
      end
    end
    bus_a.d1 = 4'd2;
  endtask

  task automatic test_enable();
    bus_a.en = 3'b101;
    for (int i = 0; i < 24; i++) begin
      step();
      n_checks++;
      if (obs_a !== exp_a) $display("FAIL enable n=%0d got=%h exp=%h", n_a, obs_a, exp_a); else n_pass++;
      if ((n_a / DIV_A) % 3 == 1) begin
        n_checks++;
        if (obs_a[9:7] !== 3'b111) $display("FAIL enable_dark got=%b exp=111", obs_a[9:7]); else n_pass++;
      end
    end
    bus_a.en = 3'b111;
  endtask

  task automatic test_blink();
    bus_a.blink = 3'b001;
    for (int i = 0; i < 96; i++) begin
      step();
      n_checks++;
      if (obs_a !== exp_a) $display("FAIL blink n=%0d got=%h exp=%h", n_a, obs_a, exp_a); else n_pass++;
    end
    bus_a.blink = 3'b000;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 48 && (n_a % 24) != 5; i++) step();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus_a.an !== 3'b111) $display("FAIL async_an_a got=%b exp=111", bus_a.an); else n_pass++;
    n_checks++;
    if (bus_a.seg !== 7'h7F) $display("FAIL async_seg_a got=%h exp=7f", bus_a.seg); else n_pass++;
    n_checks++;
    if (bus_b.an !== 3'b111) $display("FAIL async_an_b got=%b exp=111", bus_b.an); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_checks++;
      if (obs_a !== exp_a) $display("FAIL async_after n=%0d got=%h exp=%h", n_a, obs_a, exp_a); else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (obs_a[9:7] !== 3'b111) $display("FAIL async_blank got=%b exp=111", obs_a[9:7]); else n_pass++;
      end
      if (i == 2) begin
        n_checks++;
        if (obs_a[9:7] !== 3'b110) $display("FAIL async_first_show got=%b exp=110", obs_a[9:7]); else n_pass++;
      end
    end
  endtask

  task automatic test_no_blank();
    for (int i = 0; i < 30; i++) begin
      step();
      n_checks++;
      if (obs_b !== exp_b) $display("FAIL no_blank n=%0d got=%h exp=%h", n_b, obs_b, exp_b); else n_pass++;
      n_checks++;
      if ($countones(~obs_b[9:7]) !== 1)
        $display("FAIL no_blank_onehot got=%b exp=one_low", obs_b[9:7]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step();
      n_checks++;
      if (obs_a !== exp_a) $display("FAIL random_a n=%0d got=%h exp=%h", n_a, obs_a, exp_a); else n_pass++;
      n_checks++;
      if (obs_b !== exp_b) $display("FAIL random_b n=%0d got=%h exp=%h", n_b, obs_b, exp_b); else n_pass++;
      if ($urandom_range(0, 3) == 0) begin
        set_inputs(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    test_reset();
    test_basic();
    test_data_change();
    test_enable();
    test_blink();
    test_async_reset();
    set_inputs(4'd4, 4'd5, 4'd6, 3'b111, 3'b000);
    test_no_blank();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexing scheduler for the 3-digit common-anode 7-segment display on the board.
- Owns the single shared segment bus and grants it to one of three digit sources per time slot, in round-robin order.
- Inserts a blanking interval at each slot change to suppress ghosting. Applies per-digit enable and blink.
- Sits between the core outputs (digit nibbles) and the board pins `seg`/`an`. Replaces the ad-hoc scan logic inside the display path.

Parameters:
- DIV, 50000: clock cycles per digit slot. Must satisfy DIV >= 2.
- BLANK, 500: cycles at the start of each slot with all anodes off. Must satisfy 0 <= BLANK < DIV.
- BLINK_LOG, 6: blink phase toggles every 2^BLINK_LOG frames. Must satisfy BLINK_LOG >= 1.

Ports:
- clk, input, 1: system clock. All logic on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- d0, input, 4: hex value for digit 0 (an[0]).
- d1, input, 4: hex value for digit 1 (an[1]).
- d2, input, 4: hex value for digit 2 (an[2]).
- en, input, 3: per-digit enable. 0 = digit dark for its whole slot.
- blink, input, 3: per-digit blink request.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- an, output, 3: anodes, active-low. At most one bit low at any time.
- frame_tick, output, 1: one-cycle pulse at the end of each full 3-slot frame.
- blink_phase, output, 1: current blink phase. 1 = blinking digits dark.

Behaviour:
- Reset (async assert, held): an = 3'b111, seg = 7'h7F, frame_tick = 0, blink_phase = 0, slot counter cnt = 0, digit index idx = 0, frame counter = 0, latched value = 0.
- Slot counter: cnt increments every clock, 0..DIV-1. At DIV-1 it wraps to 0 and idx advances 0->1->2->0.
- Per-slot phases, as a two-state machine:
  - BLANK: cnt < BLANK.
  - SHOW: cnt >= BLANK.
  - BLANK = 0: SHOW spans the whole slot.
- Value latch: on the clock edge where cnt becomes BLANK (or becomes 0 when BLANK = 0), d[idx] is captured into an internal 4-bit register. Input changes during SHOW do not affect the displayed glyph until the next slot.
- Outputs are registered. On each edge, `an`/`seg` reflect the post-edge cnt/idx/latched value, giving zero-cycle phase latency:
  - SHOW with en[idx]=1 and !(blink[idx] && blink_phase): an = ~(3'b001 << idx), seg = hex glyph of latched value.
  - All other cases: an = 3'b111, seg = 7'h7F.
- Hex glyphs (active-low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- frame_tick: high for exactly the cycle following the edge where cnt wraps with idx = 2, i.e. the first cycle of the new digit-0 slot.
- Blink: a BLINK_LOG-bit frame counter increments on each frame_tick. When it wraps to 0, blink_phase toggles. blink_phase changes only at frame boundaries.
- Mid-slot changes to en or blink take effect on the next clock; no wait for the slot boundary.
- Reset mid-slot: outputs blank immediately (asynchronous). After release, the first SHOW begins BLANK cycles later on digit 0.
- Parameter violations (BLANK >= DIV, DIV < 2) are caught by an elaboration-time check that stops simulation.

Decomposition:
- Shared package holds:
  - the 16-entry glyph constant table (SEG_BLANK = 7'h7F);
  - AN_OFF = 3'b111;
  - NDIG = 3.
- One sub-module, seg_hex_decode: combinational 4-bit to 7-bit active-low decoder. It is reused by the existing display driver.
- Counters, the FSM and the output registers stay in seg_scan_ctrl.

Test Plan (DIV=8, BLANK=2, BLINK_LOG=1 unless stated):
1. Reset, release, d0=1, d1=2, d2=3, en=7, blink=0 -> per slot: 2 cycles an=111/seg=7F, then 6 cycles with the digit shown. Sequence an=110/seg=79, an=101/seg=24, an=011/seg=30, repeating. frame_tick pulses every 24 cycles.
2. Change d1 from 2 to F midway through the digit-1 SHOW phase -> seg stays 24 for the rest of that slot. Next digit-1 slot shows 0E.
3. en=3'b101 -> the digit-1 slot is fully dark (an=111, seg=7F). Digits 0 and 2 are unaffected.
4. blink=3'b001, 4 frames -> blink_phase toggles every 2 frames. Digit 0 is dark during phase=1 frames. Digits 1 and 2 are always lit.
5. Assert rst asynchronously mid-SHOW (between clock edges) -> an=111 and seg=7F immediately. After release, digit 0 reappears exactly 2 cycles later.
6. BLANK=0, DIV=4 -> no blank cycles. Exactly one anode low on every cycle; never two low in the same cycle across slot boundaries.
